fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// Instruction-fetch stage. Sits directly upstream of decode_stage and owns the PC register.
// Issues one instruction-memory request at a time and buffers one early response.
// Drives the IF/ID pipeline register (instruction, pc, if_valid) that decode consumes.
// Obeys decode's PCWrite/FetchWrite stall controls and its PCSrc/pc_branch redirect.
// PARAMETERS
// RESET_PC   32'h0000_0000  PC of the first fetch after reset
// NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0) driven while if_valid=0
// PORTS
// clk          in   1   clock; all state updates on posedge
// rst          in   1   reset; synchronous, active-high
// PCWrite      in   1   0 = hold PC and block new requests (load-use stall)
// FetchWrite   in   1   0 = hold IF/ID register contents
// PCSrc        in   1   1 = branch taken in decode, redirect to pc_branch
// pc_branch    in   32  redirect target
// imem_req     out  1   request valid
// imem_addr    out  32  request byte address (= pc_q)
// imem_ready   in   1   memory accepts the request this cycle
// imem_rvalid  in   1   response valid; earliest 1 cycle after accept
// imem_rdata   in   32  response instruction word
// instruction  out  32  IF/ID instruction
// pc           out  32  IF/ID pc of instruction
// if_valid     out  1   IF/ID holds a real instruction
// BEHAVIOUR
// - Reset (clk edge with rst=1) overrides everything: state=FETCH, pc_q=RESET_PC, drop=0, buf_valid=0,
//   instruction=NOP_INSTR, pc=RESET_PC, if_valid=0, imem_req=0 in the reset cycle.
// - redirect = PCSrc & PCWrite. PCSrc is ignored while PCWrite=0.
// - FSM FETCH: imem_req = !buf_valid & PCWrite & !redirect (combinational). imem_addr=pc_q.
//   On accept (imem_req & imem_ready): req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32, wraps), go to WAIT.
//   Without accept, imem_req and imem_addr stay stable until accept, redirect, or stall.
//   imem_rvalid in FETCH is ignored.
// - FSM WAIT: imem_req=0. On imem_rvalid:
//   - drop=1: discard, drop<=0.
//   - otherwise: response goes to IF/ID if FetchWrite=1 and buf is empty; else to buf
//     (buf_valid<=1, buf_instr, buf_pc=req_pc).
//   - In all rvalid cases: go to FETCH.
//   Only one request is ever outstanding, so throughput is 1 instruction per 2 cycles
//   with a zero-wait memory.
// - IF/ID update, priority order:
//   - FetchWrite=0: hold all IF/ID outputs.
//   - Else redirect: instruction<=NOP_INSTR, if_valid<=0, pc unchanged.
//   - Else buf_valid: load buf into IF/ID, buf_valid<=0.
//   - Else non-dropped rvalid: load imem_rdata and req_pc, if_valid<=1.
//   - Else: bubble (NOP_INSTR, if_valid=0).
// - Redirect effects:
//   - pc_q<=pc_branch, buf_valid<=0.
//   - In WAIT without rvalid this cycle: drop<=1.
//   - In WAIT with rvalid this cycle: the response is discarded.
//   - Redirect with FetchWrite=0 still updates pc_q and drop but holds IF/ID.
// - PCWrite=0: pc_q holds. An outstanding response is still captured per the rules above.
// - buf is never overwritten: at most one outstanding request, and no issue while buf_valid.
// TESTING
// 1. rst 2 cycles, ready=1, rvalid 1 cycle after accept, rdata=0x00500093
//    -> imem_addr=0, then IF/ID={0x00500093, pc=0, valid=1}, next imem_addr=4.
// 2. FetchWrite=0 for 3 cycles while response 0x00A00113 for pc 4 returns
//    -> IF/ID holds old value, buf_valid=1, imem_req=0; FetchWrite=1 -> IF/ID={0x00A00113, pc=4, valid=1}.
// 3. PCSrc=1, pc_branch=0x40 in WAIT; rvalid arrives next cycle
//    -> response discarded, IF/ID=NOP with valid=0, next imem_addr=0x40.
// 4. imem_ready=0 for 5 cycles -> imem_req=1 and imem_addr=8 stable for all 5; pc_q advances only on accept.
// 5. rst during WAIT, stray rvalid 1 cycle after reset release
//    -> all outputs at reset values, rvalid ignored, first imem_addr=RESET_PC.
// 6. PCSrc=1 with PCWrite=0 -> pc_q unchanged, no flush.
//    Also: pc_q=0xFFFFFFFC accept -> pc_q wraps to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, buffers one
// early response and drives the IF/ID register consumed by decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        FetchWrite,
    input  logic        PCSrc,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        if_valid
);

    typedef enum logic {S_FETCH, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] req_pc;
    logic        drop;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic redirect, accept, rsp, rsp_keep, to_ifid;

    assign redirect  = PCSrc & PCWrite;
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;
    assign rsp       = (state_q == S_WAIT) & imem_rvalid;
    // A response is kept only if it was not flushed earlier (drop) or in this same cycle.
    assign rsp_keep  = rsp & ~drop & ~redirect;
    assign to_ifid   = rsp_keep & FetchWrite & ~buf_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = ~rst & ~buf_valid & PCWrite & ~redirect;
                if (imem_req && imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            drop        <= 1'b0;
            buf_valid   <= 1'b0;
            instruction <= NOP_INSTR;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
        end else begin
            if (redirect)    pc_q <= pc_branch;
            else if (accept) pc_q <= pc_q + 32'd4;

            if (redirect && state_q == S_WAIT && !imem_rvalid) drop <= 1'b1;
            else if (rsp)                                      drop <= 1'b0;

            if (redirect)                 buf_valid <= 1'b0;
            else if (rsp_keep && !to_ifid) buf_valid <= 1'b1;
            else if (FetchWrite && buf_valid) buf_valid <= 1'b0;

            if (FetchWrite) begin
                if (redirect) begin
                    instruction <= NOP_INSTR;
                    if_valid    <= 1'b0;
                end else if (buf_valid) begin
                    instruction <= buf_instr;
                    pc          <= buf_pc;
                    if_valid    <= 1'b1;
                end else if (rsp_keep) begin
                    instruction <= imem_rdata;
                    pc          <= req_pc;
                    if_valid    <= 1'b1;
                end else begin
                    instruction <= NOP_INSTR;
                    if_valid    <= 1'b0;
                end
            end
        end
    end

    // Data-only registers: qualified by control state, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) req_pc <= pc_q;
        if (rsp_keep && !to_ifid) begin
            buf_instr <= imem_rdata;
            buf_pc    <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: per-cycle input/expectation table plus
// hand-written sequences for reset-during-wait and PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        FetchWrite;
    logic        PCSrc;
    logic [31:0] pc_branch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .FetchWrite(FetchWrite),
        .PCSrc(PCSrc), .pc_branch(pc_branch), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
        .if_valid(if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pw, fw, src;
        logic [31:0] br;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        e_req, chk_addr;
        logic [31:0] e_addr, e_ins, e_pc;
        logic        e_vld;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, pw, fw, src, input logic [31:0] br,
                                input logic rdy, rv, input logic [31:0] rd,
                                input logic req, ca, input logic [31:0] addr,
                                input logic [31:0] ins, pcv, input logic vld);
        vec_t v;
        v.rst = r; v.pw = pw; v.fw = fw; v.src = src; v.br = br;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = req; v.chk_addr = ca; v.e_addr = addr;
        v.e_ins = ins; v.e_pc = pcv; v.e_vld = vld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs held for one cycle; imem_req/addr checked during it, IF/ID after its closing edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        rst = v.rst; PCWrite = v.pw; FetchWrite = v.fw; PCSrc = v.src;
        pc_branch = v.br; imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rd;
        #1;
        check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, v.e_req});
        if (v.chk_addr) check({tag, ".imem_addr"}, imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        check({tag, ".instruction"}, instruction, v.e_ins);
        check({tag, ".pc"}, pc, v.e_pc);
        check({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v.e_vld});
    endtask

    initial begin
        rst = 1'b1; PCWrite = 1'b1; FetchWrite = 1'b1; PCSrc = 1'b0; pc_branch = '0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

        //            rst pw fw src br            rdy rv rdata          req ca addr           instr          pc            v
        vecs[0]  = mk(1, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        NOP,           32'h0,        0);
        vecs[1]  = mk(1, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h0,        NOP,           32'h0,        0);
        vecs[2]  = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h0,        NOP,           32'h0,        0);
        vecs[3]  = mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h00500093, 0, 1, 32'h4,        32'h00500093,  32'h0,        1);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h4,        32'h00500093,  32'h0,        1);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h00A00113, 0, 1, 32'h8,        32'h00500093,  32'h0,        1);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h8,        32'h00500093,  32'h0,        1);
        vecs[7]  = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h8,        32'h00A00113,  32'h4,        1);
        for (int i = 8; i < 13; i++)
            vecs[i] = mk(0, 1, 1, 0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h8,        NOP,           32'h4,        0);
        vecs[13] = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h8,        NOP,           32'h4,        0);
        vecs[14] = mk(0, 1, 1, 1, 32'h40,       1, 0, 32'h0,        0, 1, 32'hC,        NOP,           32'h4,        0);
        vecs[15] = mk(0, 1, 1, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 1, 32'h40,       NOP,           32'h4,        0);
        vecs[16] = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h40,       NOP,           32'h4,        0);
        vecs[17] = mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h00000033, 0, 1, 32'h44,       32'h00000033,  32'h40,       1);
        vecs[18] = mk(0, 0, 1, 1, 32'h80,       1, 0, 32'h0,        0, 1, 32'h44,       NOP,           32'h40,       0);
        vecs[19] = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h44,       NOP,           32'h40,       0);
        vecs[20] = mk(0, 0, 1, 0, 32'h0,        1, 1, 32'h11111111, 0, 1, 32'h48,       32'h11111111,  32'h44,       1);
        vecs[21] = mk(0, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h48,       NOP,           32'h44,       0);
        vecs[22] = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h48,       NOP,           32'h44,       0);
        vecs[23] = mk(0, 1, 1, 1, 32'h100,      1, 1, 32'h22222222, 0, 1, 32'h4C,       NOP,           32'h44,       0);
        vecs[24] = mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'h100,      NOP,           32'h44,       0);
        vecs[25] = mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h33333333, 0, 1, 32'h104,      32'h33333333,  32'h100,      1);

        for (int i = 0; i < NV; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Reset while a request is outstanding; stray rvalid afterwards must be ignored.
        step("rstw.issue", mk(0, 1, 1, 0, 32'h0, 1, 0, 32'h0,        1, 1, 32'h104, NOP, 32'h100, 0));
        step("rstw.reset", mk(1, 1, 1, 0, 32'h0, 1, 0, 32'h0,        0, 0, 32'h0,   NOP, 32'h0,   0));
        step("rstw.stray", mk(0, 1, 1, 0, 32'h0, 0, 1, 32'h44444444, 1, 1, 32'h0,   NOP, 32'h0,   0));
        step("rstw.hold",  mk(0, 1, 1, 0, 32'h0, 0, 0, 32'h0,        1, 1, 32'h0,   NOP, 32'h0,   0));

        // PC wraps from 0xFFFFFFFC to 0 on accept.
        step("wrap.redir", mk(0, 1, 1, 1, 32'hFFFFFFFC, 1, 0, 32'h0,        0, 1, 32'h0,        NOP,          32'h0,        0));
        step("wrap.issue", mk(0, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hFFFFFFFC, NOP,          32'h0,        0));
        step("wrap.resp",  mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h55555555, 0, 1, 32'h0,        32'h55555555, 32'hFFFFFFFC, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
